pc_stack_unit: RTL

- Parametrised program-counter block for the CPU fetch stage.
- Generalises the 8-bit load/increment register to configurable width.
- Adds signed relative branch, call/return via an internal LIFO return-address stack, and sticky stack-error flags.
- Feeds instruction-memory address; control comes from the decode/control unit.

---
 rtl/pc_stack_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter for the fetch stage with absolute jump,
// sequential advance, signed relative branch, call/return through a small
// register-based return-address stack, and sticky stack-error flags.

// One return-address register. It has no reset because stale contents are
// never visible: depth alone decides which entries are live.
module pc_stack_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture the pushed return address; otherwise hold.
    always_ff @(posedge clk) begin
        if (we) q <= d;
    end

endmodule

module pc_stack_unit #(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    localparam int              DW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch,
    input  logic             inc,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc_out,
    output logic [DW-1:0]    depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    // The single command that wins this cycle.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_RET,
        OP_CALL,
        OP_LATCH,
        OP_BRANCH,
        OP_INC
    } op_t;

    // Decoded per-cycle action; everything downstream works from this.
    typedef struct packed {
        op_t              op;
        logic             push;
        logic             pop;
        logic             ovf_ev;
        logic             unf_ev;
        logic [WIDTH-1:0] pc_nxt;
        logic [DW-1:0]    depth_nxt;
    } act_t;

    logic [STACK_DEPTH-1:0][WIDTH-1:0] stk_q;
    logic [STACK_DEPTH-1:0]            stk_we;
    logic [WIDTH-1:0]                  ret_addr;
    logic [WIDTH-1:0]                  pc_plus1;
    op_t                               op;
    act_t                              act;

    assign stack_full  = (depth == DW'(STACK_DEPTH));
    assign stack_empty = (depth == '0);
    assign pc_plus1    = pc_out + WIDTH'(1);

    // Priority select: ret > call > latch > branch > inc. Reset is handled in
    // the register process, so a reset cycle never decodes a command.
    always_comb begin
        op = OP_NONE;
        if (reset)       op = OP_NONE;
        else if (ret)    op = OP_RET;
        else if (call)   op = OP_CALL;
        else if (latch)  op = OP_LATCH;
        else if (branch) op = OP_BRANCH;
        else if (inc)    op = OP_INC;
    end

    // Read the top-of-stack entry (index depth-1); zero when empty.
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth == DW'(i + 1)) ret_addr = stk_q[i];
        end
    end

    // Next pc/depth and error events. A call on a full stack and a ret on an
    // empty stack are complete no-ops apart from raising their flag.
    always_comb begin
        act           = '0;
        act.op        = op;
        act.pc_nxt    = pc_out;
        act.depth_nxt = depth;
        unique case (op)
            OP_RET: begin
                if (stack_empty) begin
                    act.unf_ev = 1'b1;
                end else begin
                    act.pop       = 1'b1;
                    act.pc_nxt    = ret_addr;
                    act.depth_nxt = depth - DW'(1);
                end
            end
            OP_CALL: begin
                if (stack_full) begin
                    act.ovf_ev = 1'b1;
                end else begin
                    act.push      = 1'b1;
                    act.pc_nxt    = data;
                    act.depth_nxt = depth + DW'(1);
                end
            end
            OP_LATCH:  act.pc_nxt = data;
            // Two's-complement add wraps naturally at WIDTH bits.
            OP_BRANCH: act.pc_nxt = pc_out + offset;
            OP_INC:    act.pc_nxt = pc_plus1;
            default:   ;
        endcase
    end

    // Only the entry at the current depth is written on a push.
    always_comb begin
        stk_we = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stk_we[i] = act.push && (depth == DW'(i));
        end
    end

    // Return-address storage, one register per entry.
    for (genvar g = 0; g < STACK_DEPTH; g++) begin : g_stk
        pc_stack_entry #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .we  (stk_we[g]),
            .d   (pc_plus1),
            .q   (stk_q[g])
        );
    end

    // pc and depth registers; reset drops the whole stack by zeroing depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= RESET_VECTOR;
            depth  <= '0;
        end else begin
            pc_out <= act.pc_nxt;
            depth  <= act.depth_nxt;
        end
    end

    // Sticky error flags: a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= act.ovf_ev | (ovf_err & ~clr_err);
            unf_err <= act.unf_ev | (unf_err & ~clr_err);
        end
    end

endmodule
